// File: rtl/bus_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg
// Shared types and constants for the two-master CPU bus arbiter.
//   state_e      : arbiter FSM states (ST_IDLE, ST_ACCESS)
//   OWN_*        : owner encodings for the last_owner register
//   ENABLEN/...  : levels of the active-low address strobe
//   RW_*         : bus direction encodings
// -----------------------------------------------------------------------------
package bus_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_e;

    // Master 0 is instruction fetch, master 1 is the memory-access stage.
    localparam logic OWN_IF  = 1'b0;
    localparam logic OWN_MEM = 1'b1;

    // Address strobe levels (strobe is active low).
    localparam logic ENABLEN    = 1'b0;
    localparam logic DISENABLEN = 1'b1;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    // Owner index of a one-hot 2-bit grant; only meaningful when gnt is non-zero.
    function automatic logic owner_of(input logic [1:0] gnt);
        return gnt[1] ? OWN_MEM : OWN_IF;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Combinational 2-way round-robin picker.
//   req_i        in  2  request per master
//   last_owner_i in  1  master that won the previous arbitration
//   gnt_o        out 2  one-hot winner, 0 when nobody requests
// A sole requester always wins; on a tie the master that did not win last
// time is chosen.
// -----------------------------------------------------------------------------
module rr_arb2
    import bus_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_owner_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        unique case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = (last_owner_i == OWN_MEM) ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
// Shares the single CPU memory bus between instruction fetch (master 0) and
// the memory-access stage (master 1). Round-robin arbitration; the winner's
// address, direction and write data are registered onto the bus and the
// active-low address strobe is held until the slave's active-low ready.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   m_req[1:0]              per-master request, held until that master's m_done
//   m0_/m1_addr,rw,wdata    per-master transfer attributes
//   m_grnt[1:0]             one-hot current owner, 0 when idle
//   m_done[1:0]             one-cycle completion strobe to the owner
//   m_err                   timeout abort flag, concurrent with m_done
//   rd_data                 read data, valid while m_done is high (0 otherwise)
//   bus_addr/rw/wdata       registered bus attributes
//   bus_as_n                address strobe, active low
//   bus_rdata, bus_rdy_n    slave read data and active-low ready
//
// Configuration:
//   BUS_ARB_TIMEOUT_EN  when defined, an ACCESS that sees no ready for
//                       TIMEOUT_CYC cycles is aborted with m_done + m_err.
//                       When undefined ACCESS waits forever and m_err is 0.
// -----------------------------------------------------------------------------
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int unsigned ADDR_W      = 30,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic [1:0]        m_req,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic              m0_rw,
    input  logic              m1_rw,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [DATA_W-1:0] m1_wdata,

    output logic [1:0]        m_grnt,
    output logic [1:0]        m_done,
    output logic              m_err,
    output logic [DATA_W-1:0] rd_data,

    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_as_n,
    output logic              bus_rw,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_rdy_n
);

    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 1023) begin : g_bad_timeout
        $error("bus_arbiter: TIMEOUT_CYC must be within 1..1023");
    end

    state_e            state_q, state_d;
    logic [1:0]        grnt_q, grnt_d;
    logic              last_owner_q, last_owner_d;
    logic              as_n_q, as_n_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic [1:0]        arb_gnt;
    logic              tmo_hit;
    logic              xfer_end;

    rr_arb2 u_rr_arb2 (
        .req_i        (m_req),
        .last_owner_i (last_owner_q),
        .gnt_o        (arb_gnt)
    );

`ifdef BUS_ARB_TIMEOUT_EN
    // Counts ACCESS cycles without ready; the abort fires in the cycle in which
    // the TIMEOUT_CYC-th unready cycle is observed.
    localparam logic [9:0] TmoLast = 10'(TIMEOUT_CYC - 1);

    logic [9:0] tmo_cnt_q, tmo_cnt_d;

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q == ST_IDLE) begin
            tmo_cnt_d = '0;
        end else if (bus_rdy_n) begin
            tmo_cnt_d = tmo_cnt_q + 10'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    // Ready wins over a coincident timeout.
    assign tmo_hit = (state_q == ST_ACCESS) && bus_rdy_n && (tmo_cnt_q == TmoLast);
`else
    assign tmo_hit = 1'b0;
`endif

    assign xfer_end = !bus_rdy_n || tmo_hit;

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        grnt_d       = grnt_q;
        last_owner_d = last_owner_q;
        as_n_d       = as_n_q;
        rw_d         = rw_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;

        unique case (state_q)
            ST_IDLE: begin
                // bus_rdy_n is deliberately not looked at here.
                if (|m_req) begin
                    state_d      = ST_ACCESS;
                    grnt_d       = arb_gnt;
                    last_owner_d = owner_of(arb_gnt);
                    as_n_d       = ENABLEN;
                    if (arb_gnt[1]) begin
                        addr_d  = m1_addr;
                        rw_d    = m1_rw;
                        wdata_d = m1_wdata;
                    end else begin
                        addr_d  = m0_addr;
                        rw_d    = m0_rw;
                        wdata_d = m0_wdata;
                    end
                end
            end
            ST_ACCESS: begin
                // Requests and attributes are ignored until the transfer ends,
                // including the owner dropping its request.
                if (xfer_end) begin
                    state_d = ST_IDLE;
                    grnt_d  = 2'b00;
                    as_n_d  = DISENABLEN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grnt_d  = 2'b00;
                as_n_d  = DISENABLEN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            grnt_q       <= 2'b00;
            last_owner_q <= OWN_MEM;
            as_n_q       <= DISENABLEN;
            rw_q         <= RW_READ;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            grnt_q       <= grnt_d;
            last_owner_q <= last_owner_d;
            as_n_q       <= as_n_d;
            rw_q         <= rw_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    // Completion is combinational on ready so a zero-wait slave finishes in
    // the first strobe cycle.
    always_comb begin
        m_done  = 2'b00;
        m_err   = 1'b0;
        rd_data = '0;
        if (state_q == ST_ACCESS && xfer_end) begin
            m_done = grnt_q;
            m_err  = tmo_hit;
            if (rw_q == RW_READ && !tmo_hit) begin
                rd_data = bus_rdata;
            end
        end
    end

    assign m_grnt    = grnt_q;
    assign bus_as_n  = as_n_q;
    assign bus_rw    = rw_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
// Directed bench for bus_arbiter: a per-cycle vector table covering a
// zero-wait read, a write with wait states, non-owner inputs during ACCESS
// and two-master contention, followed by hand-written sequences for reset,
// owner dropping its request, asynchronous reset mid-ACCESS and the stall /
// timeout behaviour (BUS_ARB_TIMEOUT_EN selects which stall variant runs).
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

    localparam int unsigned ADDR_W = 30;
    localparam int unsigned DATA_W = 32;

    logic              clk;
    logic              rst_n;
    logic [1:0]        m_req;
    logic [ADDR_W-1:0] m0_addr, m1_addr;
    logic              m0_rw, m1_rw;
    logic [DATA_W-1:0] m0_wdata, m1_wdata;
    logic [1:0]        m_grnt;
    logic [1:0]        m_done;
    logic              m_err;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] bus_addr;
    logic              bus_as_n;
    logic              bus_rw;
    logic [DATA_W-1:0] bus_wdata;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_rdy_n;

    int errors = 0;
    int checks = 0;

    bus_arbiter #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m_req     (m_req),
        .m0_addr   (m0_addr),
        .m1_addr   (m1_addr),
        .m0_rw     (m0_rw),
        .m1_rw     (m1_rw),
        .m0_wdata  (m0_wdata),
        .m1_wdata  (m1_wdata),
        .m_grnt    (m_grnt),
        .m_done    (m_done),
        .m_err     (m_err),
        .rd_data   (rd_data),
        .bus_addr  (bus_addr),
        .bus_as_n  (bus_as_n),
        .bus_rw    (bus_rw),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_rdy_n (bus_rdy_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]        req;
        logic [ADDR_W-1:0] a0;
        logic [ADDR_W-1:0] a1;
        logic              rw0;
        logic              rw1;
        logic [DATA_W-1:0] wd0;
        logic [DATA_W-1:0] wd1;
        logic [DATA_W-1:0] rdata;
        logic              rdy_n;
        logic [1:0]        e_grnt;
        logic              e_as_n;
        logic [ADDR_W-1:0] e_addr;
        logic              e_rw;
        logic [DATA_W-1:0] e_wdata;
        logic [1:0]        e_done;
        logic [DATA_W-1:0] e_rd;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks happen on the
    // falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ctl(input string tag, input logic [1:0] grnt, input logic as_n,
                           input logic [1:0] done, input logic err);
        chk({tag, " grnt"}, 32'(m_grnt), 32'(grnt));
        chk({tag, " as_n"}, 32'(bus_as_n), 32'(as_n));
        chk({tag, " done"}, 32'(m_done), 32'(done));
        chk({tag, " err"},  32'(m_err), 32'(err));
    endtask

    initial begin
        // Table: inputs for this cycle | expected grnt, as_n, addr, rw, wdata, done, rd_data
        vecs[0]  = '{2'b01, 30'h100, 30'h0,   1'b0, 1'b0, 32'h0,  32'h0,        32'hDEADBEEF, 1'b0,
                     2'b00, 1'b1, 30'h0,   1'b0, 32'h0,        2'b00, 32'h0};
        vecs[1]  = '{2'b01, 30'h100, 30'h0,   1'b0, 1'b0, 32'h0,  32'h0,        32'hDEADBEEF, 1'b0,
                     2'b01, 1'b0, 30'h100, 1'b0, 32'h0,        2'b01, 32'hDEADBEEF};
        vecs[2]  = '{2'b00, 30'h100, 30'h0,   1'b0, 1'b0, 32'h0,  32'h0,        32'hDEADBEEF, 1'b0,
                     2'b00, 1'b1, 30'h100, 1'b0, 32'h0,        2'b00, 32'h0};
        vecs[3]  = '{2'b10, 30'h100, 30'h2AA, 1'b0, 1'b1, 32'h0,  32'h12345678, 32'hDEADBEEF, 1'b1,
                     2'b00, 1'b1, 30'h100, 1'b0, 32'h0,        2'b00, 32'h0};
        vecs[4]  = '{2'b10, 30'h100, 30'h2AA, 1'b0, 1'b1, 32'h0,  32'h12345678, 32'hDEADBEEF, 1'b1,
                     2'b10, 1'b0, 30'h2AA, 1'b1, 32'h12345678, 2'b00, 32'h0};
        vecs[5]  = '{2'b11, 30'h3FF, 30'h2AA, 1'b0, 1'b1, 32'h0,  32'h12345678, 32'hDEADBEEF, 1'b1,
                     2'b10, 1'b0, 30'h2AA, 1'b1, 32'h12345678, 2'b00, 32'h0};
        vecs[6]  = '{2'b11, 30'h3FF, 30'h2AA, 1'b0, 1'b1, 32'h0,  32'h12345678, 32'hDEADBEEF, 1'b1,
                     2'b10, 1'b0, 30'h2AA, 1'b1, 32'h12345678, 2'b00, 32'h0};
        vecs[7]  = '{2'b10, 30'h3FF, 30'h2AA, 1'b0, 1'b1, 32'h0,  32'h12345678, 32'hDEADBEEF, 1'b0,
                     2'b10, 1'b0, 30'h2AA, 1'b1, 32'h12345678, 2'b10, 32'h0};
        vecs[8]  = '{2'b00, 30'h3FF, 30'h2AA, 1'b0, 1'b1, 32'h0,  32'h12345678, 32'hDEADBEEF, 1'b0,
                     2'b00, 1'b1, 30'h2AA, 1'b1, 32'h12345678, 2'b00, 32'h0};
        vecs[9]  = '{2'b11, 30'h010, 30'h020, 1'b0, 1'b0, 32'hAA, 32'h12345678, 32'hA5A5A5A5, 1'b0,
                     2'b00, 1'b1, 30'h2AA, 1'b1, 32'h12345678, 2'b00, 32'h0};
        for (int i = 10; i < 17; i++) begin
            vecs[i] = vecs[9];
            if ((i % 2) == 0) begin
                // Grants alternate: owner 0 on rows 10 and 14, owner 1 on 12 and 16.
                vecs[i].e_grnt  = (i % 4 == 2) ? 2'b01 : 2'b10;
                vecs[i].e_as_n  = 1'b0;
                vecs[i].e_addr  = (i % 4 == 2) ? 30'h010 : 30'h020;
                vecs[i].e_wdata = (i % 4 == 2) ? 32'hAA : 32'h12345678;
                vecs[i].e_done  = vecs[i].e_grnt;
                vecs[i].e_rd    = 32'hA5A5A5A5;
            end else begin
                vecs[i].e_addr  = (i % 4 == 3) ? 30'h010 : 30'h020;
                vecs[i].e_wdata = (i % 4 == 3) ? 32'hAA : 32'h12345678;
            end
            vecs[i].e_rw = 1'b0;
        end
        vecs[17] = '{2'b00, 30'h010, 30'h020, 1'b0, 1'b0, 32'hAA, 32'h12345678, 32'hA5A5A5A5, 1'b1,
                     2'b00, 1'b1, 30'h020, 1'b0, 32'h12345678, 2'b00, 32'h0};

        // Reset held for several cycles
        rst_n = 1'b0;
        m_req = 2'b00; m0_addr = '0; m1_addr = '0; m0_rw = 1'b0; m1_rw = 1'b0;
        m0_wdata = '0; m1_wdata = '0; bus_rdata = '0; bus_rdy_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_ctl("reset", 2'b00, 1'b1, 2'b00, 1'b0);
        chk("reset addr",  32'(bus_addr), 32'h0);
        chk("reset rw",    32'(bus_rw), 32'h0);
        chk("reset wdata", bus_wdata, 32'h0);
        next_cycle();
        rst_n = 1'b1;

        // Table-driven cycles
        for (int i = 0; i < NVEC; i++) begin
            m_req = vecs[i].req; m0_addr = vecs[i].a0; m1_addr = vecs[i].a1;
            m0_rw = vecs[i].rw0; m1_rw = vecs[i].rw1;
            m0_wdata = vecs[i].wd0; m1_wdata = vecs[i].wd1;
            bus_rdata = vecs[i].rdata; bus_rdy_n = vecs[i].rdy_n;
            @(negedge clk);
            chk_ctl($sformatf("row%0d", i), vecs[i].e_grnt, vecs[i].e_as_n, vecs[i].e_done, 1'b0);
            chk($sformatf("row%0d addr", i),  32'(bus_addr), 32'(vecs[i].e_addr));
            chk($sformatf("row%0d rw", i),    32'(bus_rw), 32'(vecs[i].e_rw));
            chk($sformatf("row%0d wdata", i), bus_wdata, vecs[i].e_wdata);
            chk($sformatf("row%0d rd", i),    rd_data, vecs[i].e_rd);
            next_cycle();
        end

        // Owner drops its request mid-ACCESS; the transfer still completes.
        m_req = 2'b01; m0_addr = 30'h055; m0_rw = 1'b0; bus_rdy_n = 1'b1;
        @(negedge clk); chk_ctl("drop idle", 2'b00, 1'b1, 2'b00, 1'b0);
        next_cycle();
        @(negedge clk); chk_ctl("drop acc1", 2'b01, 1'b0, 2'b00, 1'b0);
        chk("drop addr", 32'(bus_addr), 32'h055);
        next_cycle();
        m_req = 2'b00;
        @(negedge clk); chk_ctl("drop acc2", 2'b01, 1'b0, 2'b00, 1'b0);
        next_cycle();
        bus_rdy_n = 1'b0;
        @(negedge clk); chk_ctl("drop done", 2'b01, 1'b0, 2'b01, 1'b0);
        chk("drop rd", rd_data, 32'hA5A5A5A5);
        next_cycle();
        bus_rdy_n = 1'b1; m_req = 2'b10; m1_addr = 30'h066; m1_rw = 1'b0;
        @(negedge clk); chk_ctl("pre-rst idle", 2'b00, 1'b1, 2'b00, 1'b0);
        next_cycle();
        @(negedge clk); chk_ctl("pre-rst acc", 2'b10, 1'b0, 2'b00, 1'b0);
        next_cycle();

        // Asynchronous reset in the middle of an ACCESS cycle.
        bus_rdy_n = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk_ctl("async rst", 2'b00, 1'b1, 2'b00, 1'b0);
        chk("async rst addr", 32'(bus_addr), 32'h0);
        @(negedge clk); chk_ctl("rst held", 2'b00, 1'b1, 2'b00, 1'b0);
        next_cycle();
        rst_n = 1'b1; m_req = 2'b00; bus_rdy_n = 1'b1;
        @(negedge clk); chk_ctl("post rst", 2'b00, 1'b1, 2'b00, 1'b0);
        next_cycle();

        // Stalled slave
        m_req = 2'b01; m0_addr = 30'h077; m0_rw = 1'b0; bus_rdata = 32'hCAFEF00D; bus_rdy_n = 1'b1;
        @(negedge clk); chk_ctl("stall idle", 2'b00, 1'b1, 2'b00, 1'b0);
        next_cycle();
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk); chk_ctl($sformatf("stall acc%0d", c), 2'b01, 1'b0, 2'b00, 1'b0);
            next_cycle();
        end
`ifdef BUS_ARB_TIMEOUT_EN
        @(negedge clk); chk_ctl("timeout", 2'b01, 1'b0, 2'b01, 1'b1);
        chk("timeout rd", rd_data, 32'h0);
        next_cycle();
        @(negedge clk); chk_ctl("after timeout", 2'b00, 1'b1, 2'b00, 1'b0);
        next_cycle();
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk); chk_ctl($sformatf("rerun acc%0d", c), 2'b01, 1'b0, 2'b00, 1'b0);
            next_cycle();
        end
        bus_rdy_n = 1'b0;
        @(negedge clk); chk_ctl("ready at limit", 2'b01, 1'b0, 2'b01, 1'b0);
        chk("ready at limit rd", rd_data, 32'hCAFEF00D);
        next_cycle();
`else
        for (int c = 4; c <= 7; c++) begin
            @(negedge clk); chk_ctl($sformatf("stall acc%0d", c), 2'b01, 1'b0, 2'b00, 1'b0);
            next_cycle();
        end
        bus_rdy_n = 1'b0;
        @(negedge clk); chk_ctl("stall done", 2'b01, 1'b0, 2'b01, 1'b0);
        chk("stall rd", rd_data, 32'hCAFEF00D);
        next_cycle();
`endif
        m_req = 2'b00; bus_rdy_n = 1'b1;
        @(negedge clk); chk_ctl("final idle", 2'b00, 1'b1, 2'b00, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
